dbg_uart_phy: RTL and testbench

Bit-level UART front end for the debug port, with automatic baud-rate detection. It deserialises `rxd` into byte strobes for the debug command decoder (`id`/`dix`) and serialises that decoder's response bytes (`od`/`dox`) onto `txd`. The baud rate is measured from the start bit of the first received character, which must be `"a"` (0x61) or `"i"` (0x69). Both characters have data bit 0 = 1, so the start-bit low time is exactly one bit period.

---
 rtl/dbg_uart_if.sv | 35 +++
 rtl/dbg_uart_phy.sv | 232 +++++++++++++++++++++++
 tb/tb_dbg_uart_phy.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dbg_uart_if.sv
// ============================================================================
// Module   : dbg_uart_if
// Brief    : Serial pins and byte handshake between the debug UART PHY and
//            the debug command decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface dbg_uart_if #(
  parameter int DIVW = 16
);
  logic            rxd;
  logic            txd;
  logic [7:0]      id;
  logic            dix;
  logic [7:0]      od;
  logic            dox;
  logic            locked;
  logic [DIVW-1:0] bitper;
  logic            tx_ovf;

  // Decoder / line side
  modport master (
    output rxd, od, dox,
    input  txd, id, dix, locked, bitper, tx_ovf
  );

  // PHY side
  modport slave (
    input  rxd, od, dox,
    output txd, id, dix, locked, bitper, tx_ovf
  );
endinterface

`default_nettype wire

// File: rtl/dbg_uart_phy.sv
// ============================================================================
// Module   : dbg_uart_phy
// Brief    : Autobaud UART front end for the debug port (RX deserialiser,
//            double-buffered TX serialiser). Optional macro:
//            DBG_UART_REBAUD_EN (a break character drops the baud lock).
// Revision : 1.0
// ============================================================================
`default_nettype none

module dbg_uart_phy #(
  parameter int DIVW   = 16,
  parameter int MINBIT = 8
) (
  input  wire logic clk,
  input  wire logic nreset,
  dbg_uart_if.slave bus
);

  localparam logic [2:0] c_AB_WAIT   = 3'd0;
  localparam logic [2:0] c_AB_MEAS   = 3'd1;
  localparam logic [2:0] c_AB_HOLD   = 3'd2;
  localparam logic [2:0] c_RX_IDLE   = 3'd3;
  localparam logic [2:0] c_RX_START  = 3'd4;
  localparam logic [2:0] c_RX_DATA   = 3'd5;
  localparam logic [2:0] c_RX_STOP   = 3'd6;
  localparam logic [2:0] c_RX_WAITHI = 3'd7;

  localparam logic [DIVW-1:0] c_CNT_MAX = {DIVW{1'b1}};
  localparam logic [DIVW-1:0] c_MINBIT  = DIVW'(MINBIT);

  logic            r_rx_s1, r_rx, r_rx_d;
  logic [2:0]      r_state;
  logic [DIVW-1:0] r_cnt;
  logic [DIVW:0]   r_tmr;
  logic [3:0]      r_bits;
  logic [7:0]      r_sh;
  logic [7:0]      r_id;
  logic            r_dix;
  logic            r_locked;
  logic [DIVW-1:0] r_bitper;

  logic            w_fall;
  logic            w_exp;
  logic [DIVW:0]   w_per;

  assign w_fall = r_rx_d & ~r_rx;
  assign w_exp  = (r_tmr == (DIVW+1)'(1));
  assign w_per  = {1'b0, r_bitper};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_rx_s1 <= 1'b1;
      r_rx    <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= bus.rxd;
      r_rx    <= r_rx_s1;
      r_rx_d  <= r_rx;
    end
  end

  // Autobaud and receive share one FSM; the lock character's bit 0 is
  // already known to be 1, so reception resumes directly at bit 1.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state  <= c_AB_WAIT;
      r_cnt    <= '0;
      r_tmr    <= '0;
      r_bits   <= '0;
      r_sh     <= '0;
      r_id     <= '0;
      r_dix    <= 1'b0;
      r_locked <= 1'b0;
      r_bitper <= '0;
    end else begin
      r_dix <= 1'b0;
      case (r_state)
        c_AB_WAIT: begin
          if (w_fall) begin
            r_cnt   <= (DIVW)'(1);
            r_state <= c_AB_MEAS;
          end
        end
        c_AB_MEAS: begin
          if (!r_rx) begin
            if (r_cnt == c_CNT_MAX) r_state <= c_AB_HOLD;
            else                    r_cnt   <= r_cnt + 1'b1;
          end else if (r_cnt < c_MINBIT) begin
            r_state <= c_AB_WAIT;
          end else begin
            r_bitper <= r_cnt;
            r_locked <= 1'b1;
            r_sh     <= 8'h80;
            r_bits   <= 4'd7;
            r_tmr    <= {1'b0, r_cnt} + {2'b00, r_cnt[DIVW-1:1]};
            r_state  <= c_RX_DATA;
          end
        end
        c_AB_HOLD: begin
          if (r_rx) r_state <= c_AB_WAIT;
        end
        c_RX_IDLE: begin
          if (w_fall) begin
            r_tmr   <= {2'b00, r_bitper[DIVW-1:1]};
            r_state <= c_RX_START;
          end
        end
        c_RX_START: begin
          if (w_exp) begin
            if (r_rx) begin
              r_state <= c_RX_IDLE;
            end else begin
              r_tmr   <= w_per;
              r_bits  <= 4'd8;
              r_state <= c_RX_DATA;
            end
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        c_RX_DATA: begin
          if (w_exp) begin
            r_sh  <= {r_rx, r_sh[7:1]};
            r_tmr <= w_per;
            if (r_bits == 4'd1) r_state <= c_RX_STOP;
            else                r_bits  <= r_bits - 1'b1;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        c_RX_STOP: begin
          if (w_exp) begin
            if (r_rx) begin
              r_id    <= r_sh;
              r_dix   <= 1'b1;
              r_state <= c_RX_IDLE;
            end else begin
`ifdef DBG_UART_REBAUD_EN
              if (r_sh == 8'h00) begin
                r_locked <= 1'b0;
                r_state  <= c_AB_HOLD;
              end else begin
                r_state  <= c_RX_WAITHI;
              end
`else
              r_state <= c_RX_WAITHI;
`endif
            end
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        c_RX_WAITHI: begin
          if (r_rx) r_state <= c_RX_IDLE;
        end
        default: r_state <= c_AB_WAIT;
      endcase
    end
  end

  logic            r_txd;
  logic            r_tx_busy;
  logic [8:0]      r_frame;
  logic [3:0]      r_tx_bits;
  logic [DIVW-1:0] r_tx_tmr;
  logic [7:0]      r_hold;
  logic            r_hold_v;
  logic            r_tx_ovf;

  logic            w_tx_acc;
  logic            w_tx_tick;
  logic            w_tx_end;
  logic            w_tx_free;

  assign w_tx_acc  = bus.dox & r_locked;
  assign w_tx_tick = r_tx_busy & (r_tx_tmr == (DIVW)'(1));
  assign w_tx_end  = w_tx_tick & (r_tx_bits == 4'd0);
  assign w_tx_free = ~r_tx_busy | w_tx_end;

  // r_frame holds {stop, data}; the start bit is driven directly on load.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_txd     <= 1'b1;
      r_tx_busy <= 1'b0;
      r_frame   <= '1;
      r_tx_bits <= '0;
      r_tx_tmr  <= '0;
      r_hold    <= '0;
      r_hold_v  <= 1'b0;
      r_tx_ovf  <= 1'b0;
    end else if (w_tx_free) begin
      if (r_hold_v || w_tx_acc) begin
        r_txd     <= 1'b0;
        r_tx_busy <= 1'b1;
        r_frame   <= {1'b1, (r_hold_v ? r_hold : bus.od)};
        r_tx_bits <= 4'd9;
        r_tx_tmr  <= r_bitper;
        r_hold_v  <= r_hold_v & w_tx_acc;
        if (r_hold_v && w_tx_acc) r_hold <= bus.od;
      end else begin
        r_tx_busy <= 1'b0;
      end
    end else begin
      if (w_tx_acc) begin
        if (!r_hold_v) begin
          r_hold   <= bus.od;
          r_hold_v <= 1'b1;
        end else begin
          r_tx_ovf <= 1'b1;
        end
      end
      if (w_tx_tick) begin
        r_txd     <= r_frame[0];
        r_frame   <= {1'b1, r_frame[8:1]};
        r_tx_bits <= r_tx_bits - 1'b1;
        r_tx_tmr  <= r_bitper;
      end else if (r_tx_busy) begin
        r_tx_tmr  <= r_tx_tmr - 1'b1;
      end
    end
  end

  assign bus.txd    = r_txd;
  assign bus.id     = r_id;
  assign bus.dix    = r_dix;
  assign bus.locked = r_locked;
  assign bus.bitper = r_bitper;
  assign bus.tx_ovf = r_tx_ovf;

endmodule

`default_nettype wire

// File: tb/tb_dbg_uart_phy.sv
// ============================================================================
// Module   : tb_dbg_uart_phy
// Brief    : Directed self-checking bench for dbg_uart_phy.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dbg_uart_phy;

  logic clk;
  logic nreset;
  int   checks;
  int   errors;
  int   n_dix;
  logic [7:0] last_id;

  dbg_uart_if #(.DIVW(16)) bus ();

  dbg_uart_phy #(.DIVW(16), .MINBIT(8)) u_dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.dix === 1'b1) begin
      n_dix   = n_dix + 1;
      last_id = bus.id;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int p, input logic stopv);
    @(negedge clk) bus.rxd = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = b[i];
      repeat (p) @(negedge clk);
    end
    bus.rxd = stopv;
    repeat (p) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (2 * p) @(negedge clk);
  endtask

  logic [39:0] exp_tx;

  initial begin
    checks     = 0;
    errors     = 0;
    n_dix      = 0;
    last_id    = 8'h00;
    nreset     = 1'b0;
    bus.rxd    = 1'b1;
    bus.od     = 8'h00;
    bus.dox    = 1'b0;
    repeat (4) @(negedge clk);
    nreset = 1'b1;
    repeat (10) @(negedge clk);

    check("rst_txd",    bus.txd,    1);
    check("rst_dix",    bus.dix,    0);
    check("rst_id",     bus.id,     0);
    check("rst_locked", bus.locked, 0);
    check("rst_bitper", bus.bitper, 0);
    check("rst_ovf",    bus.tx_ovf, 0);

    // short glitch must not lock
    bus.rxd = 1'b0;
    repeat (3) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_locked", bus.locked, 0);
    check("glitch_dix",    n_dix,      0);

    send_byte(8'h69, 20, 1'b1);
    check("i_locked", bus.locked, 1);
    check("i_bitper", bus.bitper, 20);
    check("i_ndix",   n_dix,      1);
    check("i_id",     last_id,    8'h69);

    send_byte(8'h61, 20, 1'b1);
    check("a_ndix", n_dix,   2);
    check("a_id",   last_id, 8'h61);

    // single frame 0x21
    exp_tx = {20'hFFFFF, 1'b1, 8'h21, 1'b0};
    @(negedge clk);
    bus.od  = 8'h21;
    bus.dox = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 201; k++) begin
      @(negedge clk);
      if (k == 0) bus.dox = 1'b0;
      check("tx21_txd", bus.txd, exp_tx[k / 20]);
    end
    check("tx21_ovf", bus.tx_ovf, 0);
    repeat (20) @(negedge clk);

    // three strobes: two frames back-to-back, third dropped
    exp_tx = {1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0, 20'h00000};
    exp_tx = {20'hFFFFF, exp_tx[39:20]};
    bus.od  = 8'h11;
    bus.dox = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 401; k++) begin
      @(negedge clk);
      if (k == 0) bus.od = 8'h22;
      if (k == 1) bus.od = 8'h33;
      if (k == 2) begin
        bus.dox = 1'b0;
        check("ovf_set", bus.tx_ovf, 1);
      end
      check("tx2_txd", bus.txd, exp_tx[k / 20]);
    end
    repeat (20) @(negedge clk);

    // framing error: no byte delivered, lock retained
    send_byte(8'h55, 20, 1'b0);
    check("ferr_ndix",   n_dix,      2);
    check("ferr_locked", bus.locked, 1);

    send_byte(8'h00, 20, 1'b0);
`ifdef DBG_UART_REBAUD_EN
    check("brk_locked", bus.locked, 0);
    check("brk_ndix",   n_dix,      2);
    send_byte(8'h61, 40, 1'b1);
    check("rb_locked", bus.locked, 1);
    check("rb_bitper", bus.bitper, 40);
    check("rb_ndix",   n_dix,      3);
    check("rb_id",     last_id,    8'h61);
`else
    check("brk_locked", bus.locked, 1);
    check("brk_ndix",   n_dix,      2);
    check("brk_bitper", bus.bitper, 20);
`endif

    // reset in the middle of a TX frame
    @(negedge clk);
    bus.od  = 8'h00;
    bus.dox = 1'b1;
    @(negedge clk);
    bus.dox = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_txd_low", bus.txd, 0);
    nreset = 1'b0;
    #1;
    check("mid_rst_txd",    bus.txd,    1);
    check("mid_rst_locked", bus.locked, 0);
    check("mid_rst_bitper", bus.bitper, 0);
    repeat (3) @(negedge clk);
    nreset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
